ftch_ibuf: RTL
==============

# ftch_ibuf

Instruction fetch buffer: generates sequential instruction fetch requests to memory, consumes in-order responses on the mem_ftch valid/packet channel, and queues fetched instructions for decode. Sits between the memory subsystem and decode, on the consumer side of the mem_ftch interface. Credit accounting guarantees the buffer always has room for every response, so the mem_ftch channel needs no backpressure. Decode redirects flush the buffer and discard stale in-flight responses.

## Interface

- DEPTH, 4, buffer entries; also the maximum number of requests in flight plus buffered instructions; power of two, at least 2.
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.

- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  reset; asynchronous, active-low.
- ftch_mem_vld  output  1  fetch request valid.
- ftch_mem_addr  output  32  fetch address, word aligned.
- ftch_mem_rdy  input  1  memory accepts the request this cycle.
- mem_ftch_vld  input  1  response valid; never backpressured.
- mem_ftch_pkt  input  mem_ftch_pkt_t  response packet with fields pc[31:0] and instr[31:0], from mem_ftch_pkg.
- redirect_vld  input  1  flush and restart fetch.
- redirect_pc  input  32  restart address; bits [1:0] ignored and treated as 0.
- ftch_dec_vld  output  1  instruction available to decode.
- ftch_dec_pc  output  32  PC of the head instruction.
- ftch_dec_instr  output  32  head instruction.
- dec_ftch_rdy  input  1  decode accepts the head instruction.

## Operation

- State:
  - fetch PC register
  - started flop
  - outstanding counter, 0..DEPTH
  - drop counter, 0..DEPTH
  - circular FIFO of {pc, instr}, with read and write pointers that wrap modulo DEPTH
  - occupancy counter, 0..DEPTH
- Credit = DEPTH - occupancy - outstanding. This value is never negative.
- Request:
  - ftch_mem_vld = started && credit != 0. It depends on register state only.
  - ftch_mem_addr = fetch PC.
  - On ftch_mem_vld && ftch_mem_rdy: fetch PC += 4 (wraps at 2^32) and outstanding += 1.
  - While ftch_mem_vld is high and not accepted, ftch_mem_addr holds. A redirect is the only exception.
- Response (mem_ftch_vld):
  - outstanding -= 1.
  - If drop == 0 and no redirect is active this cycle: write {pkt.pc, pkt.instr} into the FIFO.
  - Otherwise the response is discarded. If drop > 0, drop -= 1.
  - A response arriving while outstanding == 0 is a protocol error. It is ignored, and a bench assertion flags it.
- Decode: ftch_dec_vld = occupancy != 0. The head entry pops on ftch_dec_vld && dec_ftch_rdy.
- Simultaneous FIFO write and pop at full or empty: both take effect and occupancy is unchanged. A write into an empty FIFO becomes visible only in the next cycle (no bypass).
- Redirect (redirect_vld high at the clock edge):
  - The FIFO is cleared: pointers and occupancy go to 0. The flush takes priority over any same-cycle pop.
  - fetch PC <= redirect_pc.
  - outstanding_next = outstanding + accepted - resp.
  - drop_next = outstanding_next. This count covers any request accepted in the redirect cycle.
  - Result: the next drop_next responses are discarded.
- Redirect while drop > 0: drop is recomputed by the same formula, so stale responses are never delivered.

## Timing

- Reset values:
  - Outputs: ftch_mem_vld 0, ftch_mem_addr RESET_PC, ftch_dec_vld 0, ftch_dec_pc 0, ftch_dec_instr 0.
  - Internal: all counters 0, started 0.
- started goes high on the first clock edge after resetn deasserts. ftch_mem_vld can first be high in the second cycle after release.
- Latency from response to decode: a response sampled at edge N sets ftch_dec_vld in cycle N+1.
- Latency from redirect to fetch: a redirect at edge N gives ftch_mem_addr = redirect_pc in cycle N+1 and ftch_dec_vld = 0 in cycle N+1.
- Throughput: one instruction per cycle, provided memory latency L satisfies DEPTH >= L + 1 and decode is always ready.
- Reset asserted mid-operation: all state clears immediately (asynchronously). In-flight responses after reset are the memory side's responsibility; memory is reset too.

## Test plan

- Reset and fill:
  - Stimulus: DEPTH=4, ftch_mem_rdy=1, no responses.
  - Response: requests to 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C on consecutive cycles, then ftch_mem_vld low with outstanding=4. All outputs are 0 or RESET_PC during reset.
- Streaming:
  - Stimulus: memory latency 1, dec_ftch_rdy=1.
  - Response: after fill, ftch_dec_vld stays high every cycle, and ftch_dec_pc increments by 4 with no gaps or duplicates.
- Backpressure:
  - Stimulus: dec_ftch_rdy=0, 4 responses returned.
  - Response: occupancy=4, ftch_mem_vld low. Raising rdy drains the 4 entries in order, and requests resume one cycle after the first pop.
- Redirect with 3 outstanding:
  - Stimulus: redirect_pc=0x80001000.
  - Response: the next 3 responses are discarded, the next request is 0x80001000, and the first ftch_dec_pc after the redirect is 0x80001000.
- Simultaneous events:
  - Stimulus: redirect in the same cycle as a response and a request acceptance, with 1 other request outstanding.
  - Response: drop = 2 and the response is discarded. No stale pc reaches decode. The flush beats a same-cycle pop.
- Reset mid-stream:
  - Stimulus: FIFO holding 2 entries, resetn pulsed low asynchronously.
  - Response: ftch_dec_vld falls immediately without waiting for a clock edge, and fetch restarts at 0xBFC00000.

Source files
------------

// File: rtl/ftch_ibuf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_ftch_pkg / ftch_ibuf                                     |
// | Description : Instruction fetch buffer. Issues sequential fetch requests,  |
// |               queues in-order responses for decode, and uses credit        |
// |               accounting so memory responses never need backpressure.      |
// |               Decode redirects flush the queue and drop stale responses.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package mem_ftch_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } mem_ftch_pkt_t;
endpackage

module ftch_ibuf #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                        clk,
    input  logic                        resetn,
    output logic                        ftch_mem_vld,
    output logic [31:0]                 ftch_mem_addr,
    input  logic                        ftch_mem_rdy,
    input  logic                        mem_ftch_vld,
    input  mem_ftch_pkg::mem_ftch_pkt_t mem_ftch_pkt,
    input  logic                        redirect_vld,
    input  logic [31:0]                 redirect_pc,
    output logic                        ftch_dec_vld,
    output logic [31:0]                 ftch_dec_pc,
    output logic [31:0]                 ftch_dec_instr,
    input  logic                        dec_ftch_rdy
);

    localparam int              c_PW       = $clog2(DEPTH);
    localparam int              c_CW       = $clog2(DEPTH + 1);
    localparam logic [c_CW:0]   c_DEPTH_X  = (c_CW + 1)'(DEPTH);
    localparam logic [31:0]     c_WORD_MSK = 32'hFFFF_FFFC;

    // Fetch-side state
    logic              r_started;
    logic [31:0]       r_pc;
    logic [c_CW-1:0]   r_outst;
    logic [c_CW-1:0]   r_drop;

    // Instruction queue state
    logic [c_CW-1:0]   r_occ;
    logic [c_PW-1:0]   r_wptr;
    logic [c_PW-1:0]   r_rptr;
    logic [31:0]       r_fifo_pc    [DEPTH];
    logic [31:0]       r_fifo_instr [DEPTH];

    logic [c_CW:0]     w_used;
    logic              w_accept;
    logic              w_resp;
    logic              w_wr;
    logic              w_pop;
    logic [c_CW-1:0]   w_outst_next;

    // Occupancy plus in-flight requests never exceeds DEPTH, so credit is
    // non-zero exactly when this sum is below DEPTH.
    assign w_used        = {1'b0, r_occ} + {1'b0, r_outst};
    assign ftch_mem_vld  = r_started && (w_used != c_DEPTH_X);
    assign ftch_mem_addr = r_pc;

    assign w_accept      = ftch_mem_vld && ftch_mem_rdy;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_resp        = mem_ftch_vld && (r_outst != '0);
    assign w_wr          = w_resp && (r_drop == '0) && !redirect_vld;
    assign w_pop         = ftch_dec_vld && dec_ftch_rdy;
    assign w_outst_next  = r_outst + c_CW'(w_accept) - c_CW'(w_resp);

    // Head of queue; data is forced to zero while empty so the outputs are
    // well defined out of reset without resetting the storage array.
    assign ftch_dec_vld   = (r_occ != '0);
    assign ftch_dec_pc    = ftch_dec_vld ? r_fifo_pc[r_rptr]    : 32'd0;
    assign ftch_dec_instr = ftch_dec_vld ? r_fifo_instr[r_rptr] : 32'd0;

    // Fetch PC, start flag, outstanding and drop counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_started <= 1'b0;
            r_pc      <= RESET_PC & c_WORD_MSK;
            r_outst   <= '0;
            r_drop    <= '0;
        end else begin
            r_started <= 1'b1;
            r_outst   <= w_outst_next;
            if (redirect_vld) begin
                // Everything still in flight after this edge is stale,
                // including a request accepted in this very cycle.
                r_pc   <= redirect_pc & c_WORD_MSK;
                r_drop <= w_outst_next;
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_resp && (r_drop != '0)) begin
                    r_drop <= r_drop - c_CW'(1);
                end
            end
        end
    end

    // Queue pointers and occupancy; a redirect flush overrides any pop
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_occ  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (redirect_vld) begin
            r_occ  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
            r_occ <= r_occ + c_CW'(w_wr) - c_CW'(w_pop);
        end
    end

    // Queue storage; only written entries are ever presented to decode
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_fifo_pc[r_wptr]    <= mem_ftch_pkt.pc;
            r_fifo_instr[r_wptr] <= mem_ftch_pkt.instr;
        end
    end

endmodule
`default_nettype wire
